// File: rtl/vram_arbiter_if.sv
// CPU-side request/acknowledge bus of the video RAM arbiter.
// The CPU is the master: it holds its request stable until the single-cycle ack.
interface vram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 2
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port map RAM arbiter: fixed display read slots every 8th active pixel,
// CPU accesses fill the remaining cycles through a small request/ack FSM.
module vram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              video_on_i,
  input  logic [11:0]       pixel_row_i,
  input  logic [11:0]       pixel_column_i,
  vram_arbiter_if.slave     cpu,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  output logic              frame_tick_o,
  output logic [7:0]        stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, CPU_WR, CPU_RD, CPU_ACK} state_t;

  state_t            state_q, state_d;
  logic              slot;
  logic              cpu_issue;
  logic              ack_state;
  logic              rd_capture;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              disp_pend_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [7:0]        stall_q;
  logic              video_on_q;
  logic              frame_tick_q;
  logic              unused_col_bits;

  // Only columns 0..1023 map onto the 128-cell-wide map.
  assign unused_col_bits = ^pixel_column_i[11:10];

  assign slot      = video_on_i && (pixel_column_i[2:0] == 3'd0);
  assign disp_addr = ADDR_W'({pixel_row_i[9:3], pixel_column_i[9:3]});

  // State register
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_issue) state_d = cpu.cpu_we ? CPU_WR : CPU_RD;
      CPU_WR:  state_d = IDLE;
      CPU_RD:  state_d = CPU_ACK;
      CPU_ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; a display slot always pre-empts a CPU issue.
  always_comb begin
    cpu_issue  = 1'b0;
    ack_state  = 1'b0;
    rd_capture = 1'b0;
    case (state_q)
      IDLE:    cpu_issue  = cpu.cpu_req && !slot;
      CPU_WR:  ack_state  = 1'b1;
      CPU_RD:  rd_capture = 1'b1;
      CPU_ACK: ack_state  = 1'b1;
      default: cpu_issue  = 1'b0;
    endcase
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (slot) begin
      ram_addr_d = disp_addr;
    end else if (cpu_issue) begin
      ram_addr_d  = cpu.cpu_addr;
      ram_wdata_d = cpu.cpu_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      disp_pend_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      cpu_rdata_q  <= '0;
      stall_q      <= 8'd0;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      // RAM data for a slot arrives one cycle after its address.
      disp_pend_q  <= slot;
      disp_valid_q <= disp_pend_q;
      if (disp_pend_q) begin
        disp_data_q <= ram_rdata_i;
      end
      if (rd_capture) begin
        cpu_rdata_q <= ram_rdata_i;
      end
      if (state_q == IDLE && cpu.cpu_req && slot && stall_q != 8'hFF) begin
        stall_q <= stall_q + 8'd1;
      end
      video_on_q   <= video_on_i;
      frame_tick_q <= video_on_q && !video_on_i && (pixel_row_i >= 12'd767);
    end
  end

  // Every output is forced low for as long as reset is held.
  assign ram_addr_o    = rst ? '0 : ram_addr_d;
  assign ram_we_o      = !rst && cpu_issue && cpu.cpu_we;
  assign ram_wdata_o   = rst ? '0 : ram_wdata_d;
  assign cpu.cpu_ack   = !rst && ack_state;
  assign cpu.cpu_rdata = rst ? '0 : cpu_rdata_q;
  assign disp_data_o   = rst ? '0 : disp_data_q;
  assign disp_valid_o  = !rst && disp_valid_q;
  assign frame_tick_o  = !rst && frame_tick_q;
  assign stall_cnt_o   = rst ? 8'd0 : stall_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered-read RAM model whose
// unwritten cells read back as address[1:0].
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        video_on = 1'b0;
  logic [11:0] row = '0;
  logic [11:0] col = '0;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_wdata;
  logic [1:0]  ram_rdata;
  logic [1:0]  disp_data;
  logic        disp_valid;
  logic        frame_tick;
  logic [7:0]  stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  vram_arbiter_if #(.ADDR_W(14), .DATA_W(2)) cpu_bus ();

  vram_arbiter #(.ADDR_W(14), .DATA_W(2)) dut (
    .clock          (clock),
    .rst            (rst),
    .video_on_i     (video_on),
    .pixel_row_i    (row),
    .pixel_column_i (col),
    .cpu            (cpu_bus),
    .ram_addr_o     (ram_addr),
    .ram_we_o       (ram_we),
    .ram_wdata_o    (ram_wdata),
    .ram_rdata_i    (ram_rdata),
    .disp_data_o    (disp_data),
    .disp_valid_o   (disp_valid),
    .frame_tick_o   (frame_tick),
    .stall_cnt_o    (stall_cnt)
  );

  always #5 clock = ~clock;

  bit [1:0] mem     [0:16383];
  bit       written [0:16383];

  always @(posedge clock) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : ram_addr[1:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_pix(input bit v, input int r, input int c);
    video_on = v;
    row = r[11:0];
    col = c[11:0];
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [13:0] a, input logic [1:0] d);
    cpu_bus.cpu_req   = req;
    cpu_bus.cpu_we    = we;
    cpu_bus.cpu_addr  = a;
    cpu_bus.cpu_wdata = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ram_addr"},   32'(ram_addr), 0);
    chk({tag, ".ram_we"},     32'(ram_we), 0);
    chk({tag, ".ram_wdata"},  32'(ram_wdata), 0);
    chk({tag, ".cpu_ack"},    32'(cpu_bus.cpu_ack), 0);
    chk({tag, ".cpu_rdata"},  32'(cpu_bus.cpu_rdata), 0);
    chk({tag, ".disp_data"},  32'(disp_data), 0);
    chk({tag, ".disp_valid"}, 32'(disp_valid), 0);
    chk({tag, ".frame_tick"}, 32'(frame_tick), 0);
    chk({tag, ".stall_cnt"},  32'(stall_cnt), 0);
  endtask

  initial begin
    // Reset with a slot and a pending write on the inputs: outputs stay 0.
    set_cpu(1'b1, 1'b1, 14'h3fff, 2'd3);
    set_pix(1'b1, 8, 16);
    settle();
    chk_all_zero("rst0");
    next_cycle(); next_cycle(); settle();
    chk_all_zero("rst2");
    next_cycle();
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, 14'h0, 2'd0);
    set_pix(1'b0, 800, 0);
    settle();
    chk("post_rst.frame_tick", 32'(frame_tick), 0);

    // Blanking write: issue immediately, ack next cycle.
    next_cycle();
    set_cpu(1'b1, 1'b1, 14'h1234, 2'd2);
    settle();
    chk("wr.issue_we",    32'(ram_we), 1);
    chk("wr.issue_addr",  32'(ram_addr), 32'h1234);
    chk("wr.issue_wdata", 32'(ram_wdata), 2);
    chk("wr.issue_ack",   32'(cpu_bus.cpu_ack), 0);
    next_cycle(); settle();
    chk("wr.ack",       32'(cpu_bus.cpu_ack), 1);
    chk("wr.ack_we",    32'(ram_we), 0);
    chk("wr.hold_addr", 32'(ram_addr), 32'h1234);
    next_cycle();
    set_cpu(1'b0, 1'b0, 14'h0, 2'd0);
    settle();
    chk("wr.ack_gone", 32'(cpu_bus.cpu_ack), 0);
    chk("wr.stall",    32'(stall_cnt), 0);
    $display("txn: blanking write 0x1234 <= 2");

    // Blanking read-back of the written cell.
    next_cycle();
    set_cpu(1'b1, 1'b0, 14'h1234, 2'd0);
    settle();
    chk("rb.issue_addr", 32'(ram_addr), 32'h1234);
    chk("rb.issue_we",   32'(ram_we), 0);
    next_cycle(); settle();
    chk("rb.no_ack_rd", 32'(cpu_bus.cpu_ack), 0);
    next_cycle(); settle();
    chk("rb.ack",   32'(cpu_bus.cpu_ack), 1);
    chk("rb.rdata", 32'(cpu_bus.cpu_rdata), 2);
    $display("txn: blanking read 0x1234 -> %0d", cpu_bus.cpu_rdata);

    // CPU read arriving in a slot: display wins, CPU issues one cycle later.
    next_cycle();
    set_cpu(1'b1, 1'b0, 14'h0005, 2'd0);
    set_pix(1'b1, 8, 16);
    settle();
    chk("slot.addr",  32'(ram_addr), 32'h0082);
    chk("slot.we",    32'(ram_we), 0);
    chk("slot.stall", 32'(stall_cnt), 0);
    next_cycle(); set_pix(1'b1, 8, 17); settle();
    chk("slot.cpu_addr", 32'(ram_addr), 32'h0005);
    chk("slot.stall1",   32'(stall_cnt), 1);
    next_cycle(); set_pix(1'b1, 8, 18); settle();
    chk("slot.no_ack",     32'(cpu_bus.cpu_ack), 0);
    chk("slot.disp_valid", 32'(disp_valid), 1);
    chk("slot.disp_data",  32'(disp_data), 2);
    next_cycle(); set_pix(1'b1, 8, 19); settle();
    chk("slot.ack",   32'(cpu_bus.cpu_ack), 1);
    chk("slot.rdata", 32'(cpu_bus.cpu_rdata), 1);
    $display("txn: read 0x0005 behind slot -> %0d", cpu_bus.cpu_rdata);
    next_cycle();
    set_cpu(1'b0, 1'b0, 14'h0, 2'd0);
    set_pix(1'b1, 8, 20);
    settle();
    chk("slot.valid_off", 32'(disp_valid), 0);

    // Short blanking on a low row, then one active line of display reads.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); set_pix(1'b0, 16, 0); settle();
      chk("blank16.frame_tick", 32'(frame_tick), 0);
    end
    chk("blank16.disp_hold", 32'(disp_data), 2);
    for (int c = 0; c < 64; c++) begin
      next_cycle(); set_pix(1'b1, 16, c); settle();
      if (c >= 2 && ((c - 2) % 8) == 0) begin
        chk($sformatf("line.valid_c%0d", c), 32'(disp_valid), 1);
        chk($sformatf("line.data_c%0d", c), 32'(disp_data), 32'(((c - 2) / 8) % 4));
      end else begin
        chk($sformatf("line.valid_c%0d", c), 32'(disp_valid), 0);
      end
    end
    $display("txn: active line of 8 display reads");
    for (int i = 0; i < 4; i++) begin
      next_cycle(); set_pix(1'b0, 16, 0); settle();
      chk("line.blank_valid", 32'(disp_valid), 0);
      chk("line.blank_hold",  32'(disp_data), 3);
    end

    // Back-to-back reads, the first one followed directly by a slot.
    next_cycle(); set_pix(1'b1, 24, 6); settle();
    next_cycle(); set_pix(1'b1, 24, 7);
    set_cpu(1'b1, 1'b0, 14'h0102, 2'd0);
    settle();
    chk("b2b.issue1_addr", 32'(ram_addr), 32'h0102);
    next_cycle(); set_pix(1'b1, 24, 8); settle();
    chk("b2b.slot_addr", 32'(ram_addr), 32'h0181);
    chk("b2b.slot_we",   32'(ram_we), 0);
    chk("b2b.rd1_noack", 32'(cpu_bus.cpu_ack), 0);
    next_cycle(); set_pix(1'b1, 24, 9); settle();
    chk("b2b.ack1",   32'(cpu_bus.cpu_ack), 1);
    chk("b2b.rdata1", 32'(cpu_bus.cpu_rdata), 2);
    $display("txn: read 0x0102 -> %0d", cpu_bus.cpu_rdata);
    next_cycle(); set_pix(1'b1, 24, 10);
    set_cpu(1'b1, 1'b0, 14'h0203, 2'd0);
    settle();
    chk("b2b.disp_valid",  32'(disp_valid), 1);
    chk("b2b.disp_data",   32'(disp_data), 1);
    chk("b2b.issue2_addr", 32'(ram_addr), 32'h0203);
    next_cycle(); set_pix(1'b1, 24, 11); settle();
    chk("b2b.rd2_noack", 32'(cpu_bus.cpu_ack), 0);
    next_cycle(); set_pix(1'b1, 24, 12); settle();
    chk("b2b.ack2",   32'(cpu_bus.cpu_ack), 1);
    chk("b2b.rdata2", 32'(cpu_bus.cpu_rdata), 3);
    chk("b2b.stall",  32'(stall_cnt), 1);
    $display("txn: read 0x0203 -> %0d", cpu_bus.cpu_rdata);
    next_cycle(); set_pix(1'b1, 24, 13);
    set_cpu(1'b0, 1'b0, 14'h0, 2'd0);

    // Permanent slot with a held write request: stall counter saturates.
    next_cycle();
    set_pix(1'b1, 24, 0);
    set_cpu(1'b1, 1'b1, 14'h0333, 2'd1);
    for (int i = 0; i < 300; i++) begin
      if (i > 0) next_cycle();
      settle();
      if (i == 0) begin
        chk("sat.we0",   32'(ram_we), 0);
        chk("sat.addr0", 32'(ram_addr), 32'h0180);
      end
      if (i == 99)  chk("sat.stall_i99",  32'(stall_cnt), 100);
      if (i == 253) chk("sat.stall_i253", 32'(stall_cnt), 254);
      if (i == 254) chk("sat.stall_i254", 32'(stall_cnt), 255);
      if (i == 255) chk("sat.stall_i255", 32'(stall_cnt), 255);
      if (i == 299) begin
        chk("sat.stall_end", 32'(stall_cnt), 255);
        chk("sat.we_end",    32'(ram_we), 0);
        chk("sat.no_ack",    32'(cpu_bus.cpu_ack), 0);
      end
    end
    $display("txn: held write across 300 slots, stall_cnt=%0d", stall_cnt);
    next_cycle();
    set_cpu(1'b0, 1'b0, 14'h0, 2'd0);
    set_pix(1'b0, 16, 0);

    // Reset in the middle of a read aborts it.
    next_cycle();
    set_pix(1'b0, 800, 0);
    set_cpu(1'b1, 1'b0, 14'h1234, 2'd0);
    settle();
    chk("abort.issue_addr", 32'(ram_addr), 32'h1234);
    next_cycle();
    rst = 1'b1;
    settle();
    chk_all_zero("abort.rst");
    next_cycle();
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, 14'h0, 2'd0);
    settle();
    chk("abort.no_ack",    32'(cpu_bus.cpu_ack), 0);
    chk("abort.stall",     32'(stall_cnt), 0);
    chk("abort.disp_data", 32'(disp_data), 0);
    chk("abort.rdata",     32'(cpu_bus.cpu_rdata), 0);
    next_cycle(); settle();
    chk("abort.no_ack2", 32'(cpu_bus.cpu_ack), 0);
    $display("txn: read 0x1234 aborted by reset");

    // Re-request after reset is a fresh transaction.
    next_cycle();
    set_cpu(1'b1, 1'b0, 14'h1234, 2'd0);
    settle();
    chk("rereq.issue_addr", 32'(ram_addr), 32'h1234);
    next_cycle(); settle();
    chk("rereq.no_ack", 32'(cpu_bus.cpu_ack), 0);
    next_cycle(); settle();
    chk("rereq.ack",   32'(cpu_bus.cpu_ack), 1);
    chk("rereq.rdata", 32'(cpu_bus.cpu_rdata), 2);
    $display("txn: re-requested read 0x1234 -> %0d", cpu_bus.cpu_rdata);
    next_cycle();
    set_cpu(1'b0, 1'b0, 14'h0, 2'd0);

    // End of the last visible line: exactly one frame tick.
    for (int i = 0; i < 2; i++) begin
      next_cycle(); set_pix(1'b1, 767, 100 + i); settle();
      chk("ft.active", 32'(frame_tick), 0);
    end
    for (int i = 0; i < 6; i++) begin
      next_cycle(); set_pix(1'b0, 767, 102 + i); settle();
      chk($sformatf("ft.blank%0d", i), 32'(frame_tick), (i == 1) ? 1 : 0);
    end
    $display("txn: frame tick at row 767");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
